// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the main-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned LineWDefault   = 64;
  localparam int unsigned AddrWDefault   = 14;
  localparam int unsigned TimeoutDefault = 15;

  typedef enum logic [2:0] {
    StIdle,
    StBusyI,
    StBusyDrd,
    StBusyDwr,
    StDone
  } state_e;

  typedef enum logic {
    ReqI = 1'b0,
    ReqD = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_wdog.sv
// Clearable saturating busy-cycle counter; expired flags the last cycle an access may wait.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache fills and D-cache fill/evict, one line at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise D always wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_W  = LineWDefault,
  parameter int unsigned ADDR_W  = AddrWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] rdata,
  output logic              err,
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_rdy
);

  state_e            state_q, state_d;
  logic              m_re_q, m_re_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [LINE_W-1:0] m_wdata_q, m_wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d, err_q, err_d;
  logic              wd_clr, wd_en, wd_expired;
  logic              d_wins, finish;

`ifdef MEM_ARB_RR_EN
  req_id_e last_grant_q, last_grant_d;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    d_wins = d_req & (~i_req | (last_grant_q == ReqI));
  end
`else
  always_comb begin
    d_wins = d_req;
  end
`endif

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    m_re_d    = m_re_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    finish    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      StIdle: begin
        if (d_wins) begin
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          wd_clr    = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_grant_d = ReqD;
`endif
          if (d_we) begin
            state_d = StBusyDwr;
            m_we_d  = 1'b1;
          end else begin
            state_d = StBusyDrd;
            m_re_d  = 1'b1;
          end
        end else if (i_req) begin
          state_d  = StBusyI;
          m_addr_d = i_addr;
          m_re_d   = 1'b1;
          wd_clr   = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_grant_d = ReqI;
`endif
        end
      end

      StBusyI, StBusyDrd, StBusyDwr: begin
        if (m_rdy) begin
          finish = 1'b1;
          if (state_q != StBusyDwr) begin
            rdata_d = m_rdata;
          end
        end else if (wd_expired) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end else begin
          wd_en = 1'b1;
        end

        if (finish) begin
          state_d = StDone;
          m_re_d  = 1'b0;
          m_we_d  = 1'b0;
          if (state_q == StBusyI) begin
            i_done_d = 1'b1;
          end else begin
            d_done_d = 1'b1;
          end
        end
      end

      // Requests are not sampled here so the requester has a cycle to drop req.
      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        m_re_d  = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      m_re_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= ReqI;
`endif
    end else begin
      state_q   <= state_d;
      m_re_q    <= m_re_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign m_re    = m_re_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign rdata   = rdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign err     = err_q;

endmodule
